// File: rtl/rd_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rd_fifo_ctrl_pkg
//   Shared buffer package used by both the read-side and the write-side FIFO
//   controllers. It holds the Gray/binary pointer conversion helpers so that
//   both clock domains encode and decode pointers the same way.
//
//   The helpers work on a fixed 32-bit word. Callers zero-extend their
//   pointer into ptr_word_t and cut the result back to their own width with
//   a size cast. Pointers must therefore be narrower than 32 bits.
// ---------------------------------------------------------------------------
package rd_fifo_ctrl_pkg;

    localparam int PTR_FN_W = 32;

    typedef logic [PTR_FN_W-1:0] ptr_word_t;

    // Binary to reflected Gray code.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary. Each binary bit is the XOR of that Gray
    // bit and every Gray bit above it. Zero-extended upper bits leave the
    // result unchanged.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_FN_W-1] = gray[PTR_FN_W-1];
        for (int i = PTR_FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rd_fifo_ctrl_sync.sv
// ---------------------------------------------------------------------------
// ptr_sync
//   Two-flop synchronizer that brings a Gray-coded pointer into the local
//   clock domain. Only one bit of a Gray pointer changes per source step, so
//   each flop stage can resolve independently without a multi-bit tear.
//
//   Ports
//     clk      in   local clock; both stages are clocked on its rising edge
//     rstn     in   asynchronous active-low reset; clears both stages
//     asyncIn  in   WIDTH-bit pointer from the foreign clock domain
//     syncOut  out  WIDTH-bit pointer, two local clock edges later
// ---------------------------------------------------------------------------
module ptr_sync #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] asyncIn,
    output logic [WIDTH-1:0] syncOut
);

    logic [WIDTH-1:0] metaStage;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            metaStage <= '0;
            syncOut   <= '0;
        end else begin
            metaStage <= asyncIn;
            syncOut   <= metaStage;
        end
    end

endmodule

// File: rtl/rd_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// rd_fifo_ctrl
//   Read-side controller of an asynchronous FIFO built around a dual-port RAM
//   that has a registered read port. The write pointer is synchronized and
//   decoded. Words are prefetched from the RAM into a registered output stage
//   backed by a one-word skid register. This sustains one word per cycle
//   while the consumer stays ready.
//
//   Handshake: a word moves to the consumer on every rising rdClk edge where
//   dataValid and dataReady are both 1. While dataValid is 1 and dataReady is
//   0, dataOut and dataValid hold steady. dataReady can be asserted at any
//   time and has no effect while dataValid is 0.
//
//   Ports
//     rdClk        in   read clock; all state is clocked on its rising edge
//     rstn         in   asynchronous active-low reset, deasserted in sync
//                       with rdClk
//     wrPtrGray    in   Gray write pointer from the write domain (async)
//     rdPtrGray    out  registered Gray read pointer to the write domain
//     memAddrOut   out  RAM read address
//     memDataIn    in   RAM read data, one edge after the address is sampled
//     dataOut      out  registered output word
//     dataValid    out  dataOut holds a valid word
//     dataReady    in   consumer accepts the word this cycle
//     empty        out  no valid word at the output (!dataValid)
//     numElements  out  words held, as seen from the read domain
// ---------------------------------------------------------------------------
module rd_fifo_ctrl
    import rd_fifo_ctrl_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  rdClk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH:0]   wrPtrGray,
    output logic [ADDR_WIDTH:0]   rdPtrGray,
    output logic [ADDR_WIDTH-1:0] memAddrOut,
    input  logic [FIFO_WIDTH-1:0] memDataIn,
    output logic [FIFO_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    input  logic                  dataReady,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   numElements
);

    localparam int PW = ADDR_WIDTH + 1;

    // The pointer arithmetic relies on the depth being a power of two that
    // matches the address width.
    if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : gDepthCheck
        $error("rd_fifo_ctrl: FIFO_DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [PW-1:0]         wrSyncGray;
    logic [PW-1:0]         wrSyncBin;
    logic [PW-1:0]         rdPtrBin;
    logic                  memPend;
    logic                  skidValid;
    logic [FIFO_WIDTH-1:0] skidData;

    logic       emptyInt;
    logic       pop;
    logic [1:0] occ;
    logic [1:0] occAfterPop;
    logic       fetch;
    logic       loadOut;
    logic       skidToOut;
    logic       loadSkid;
    logic       dataValidNext;
    logic       skidValidNext;

    ptr_sync #(
        .WIDTH (PW)
    ) uWrSync (
        .clk     (rdClk),
        .rstn    (rstn),
        .asyncIn (wrPtrGray),
        .syncOut (wrSyncGray)
    );

    assign wrSyncBin = PW'(gray2bin(ptr_word_t'(wrSyncGray)));
    assign emptyInt  = (wrSyncBin == rdPtrBin);

    // Local occupancy counts the output word, the skid word and the RAM read
    // in flight. It never exceeds 2, because a fetch is only issued when at
    // most one word stays local after this cycle's pop.
    assign pop         = dataValid & dataReady;
    assign occ         = {1'b0, dataValid} + {1'b0, skidValid} + {1'b0, memPend};
    assign occAfterPop = occ - {1'b0, pop};
    assign fetch       = !emptyInt && (occAfterPop < 2'd2);

    // The returning RAM word goes straight to the output if the output slot
    // is free (or being popped) and nothing older sits in the skid register.
    // Otherwise it parks in the skid register. A pop with a skid word
    // promotes the skid word so that words stay in order.
    always_comb begin
        loadOut       = memPend && (!dataValid || pop) && !skidValid;
        skidToOut     = pop && skidValid;
        loadSkid      = memPend && !loadOut;
        dataValidNext = (dataValid && !pop) || skidToOut || loadOut;
        skidValidNext = (skidValid && !pop) || loadSkid;
    end

    always_ff @(posedge rdClk or negedge rstn) begin
        if (!rstn) begin
            rdPtrBin  <= '0;
            rdPtrGray <= '0;
            memPend   <= 1'b0;
        end else begin
            rdPtrBin  <= rdPtrBin + PW'(fetch);
            memPend   <= fetch;
            // Registered from the current binary pointer, so the write side
            // sees space consumed at fetch time, one cycle after the address
            // was issued.
            rdPtrGray <= PW'(bin2gray(ptr_word_t'(rdPtrBin)));
        end
    end

    always_ff @(posedge rdClk or negedge rstn) begin
        if (!rstn) begin
            dataOut   <= '0;
            dataValid <= 1'b0;
            skidData  <= '0;
            skidValid <= 1'b0;
        end else begin
            dataValid <= dataValidNext;
            skidValid <= skidValidNext;
            if (skidToOut) begin
                dataOut <= skidData;
            end else if (loadOut) begin
                dataOut <= memDataIn;
            end
            if (loadSkid) begin
                skidData <= memDataIn;
            end
        end
    end

    assign memAddrOut  = rdPtrBin[ADDR_WIDTH-1:0];
    assign empty       = !dataValid;
    assign numElements = wrSyncBin - rdPtrBin + PW'(occ);

endmodule

// File: tb/tb_rd_fifo_ctrl.sv
module tb_rd_fifo_ctrl;

  localparam int W     = 8;
  localparam int AW    = 6;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 64;

  // clock / reset
  logic rdClk = 1'b0;
  logic rstn;
  always #5 rdClk = ~rdClk;

  logic [PW-1:0] wrPtrGray;
  logic [PW-1:0] rdPtrGray;
  logic [AW-1:0] memAddrOut;
  logic [W-1:0]  memDataIn;
  logic [W-1:0]  dataOut;
  logic          dataValid;
  logic          dataReady;
  logic          empty;
  logic [PW-1:0] numElements;

  rd_fifo_ctrl #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .rdClk       (rdClk),
    .rstn        (rstn),
    .wrPtrGray   (wrPtrGray),
    .rdPtrGray   (rdPtrGray),
    .memAddrOut  (memAddrOut),
    .memDataIn   (memDataIn),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .dataReady   (dataReady),
    .empty       (empty),
    .numElements (numElements)
  );

  // RAM model with registered read port; written by the bench's writer
  logic [W-1:0] mem [DEPTH];
  always @(posedge rdClk) memDataIn <= mem[memAddrOut];

  // reference model: words written, in order, not yet consumed
  logic [W-1:0]  exp_q[$];
  logic [PW-1:0] wr_bin;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // driver tasks
  task automatic write_word();
    logic [W-1:0] d;
    d = W'($urandom);
    mem[wr_bin[AW-1:0]] = d;
    exp_q.push_back(d);
    wr_bin = wr_bin + 1'b1;
    wrPtrGray = to_gray(wr_bin);
  endtask

  task automatic apply_reset();
    @(negedge rdClk);
    rstn = 1'b0;
    dataReady = 1'b0;
    wr_bin = '0;
    wrPtrGray = '0;
    exp_q.delete();
    repeat (3) @(negedge rdClk);
    rstn = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge rdClk);
    rstn = 1'b0;
    #1;
    n_checks++;
    if (dataValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", dataValid); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    n_checks++;
    if (rdPtrGray !== '0) begin n_fail++; $display("FAIL reset_rdptr: got %0h expected 0", rdPtrGray); end
    n_checks++;
    if (numElements !== '0) begin n_fail++; $display("FAIL reset_num: got %0d expected 0", numElements); end
    n_checks++;
    if (dataOut !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", dataOut); end
    apply_reset();
  endtask

  task automatic test_single_word();
    apply_reset();
    @(negedge rdClk);
    write_word();
    for (int e = 1; e <= 4; e++) begin
      @(negedge rdClk);
      n_checks++;
      if (dataValid !== (e == 4)) begin
        n_fail++;
        $display("FAIL single_latency_edge%0d: got %0b expected %0b", e, dataValid, (e == 4));
      end
    end
    n_checks++;
    if (dataOut !== exp_q[0]) begin n_fail++; $display("FAIL single_data: got %0h expected %0h", dataOut, exp_q[0]); end
    n_checks++;
    if (numElements !== 7'd1) begin n_fail++; $display("FAIL single_num: got %0d expected 1", numElements); end
    n_checks++;
    if (rdPtrGray !== 7'd1) begin n_fail++; $display("FAIL single_rdptr: got %0h expected 1", rdPtrGray); end
    dataReady = 1'b1;
    void'(exp_q.pop_front());
    @(negedge rdClk);
    dataReady = 1'b0;
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL single_drained_empty: got %0b expected 1", empty); end
    n_checks++;
    if (numElements !== 7'd0) begin n_fail++; $display("FAIL single_drained_num: got %0d expected 0", numElements); end
  endtask

  task automatic test_stall();
    int waited;
    apply_reset();
    @(negedge rdClk);
    repeat (3) write_word();
    waited = 0;
    while (dataValid !== 1'b1 && waited < 10) begin
      @(negedge rdClk);
      waited++;
    end
    repeat (8) begin
      n_checks++;
      if (dataValid !== 1'b1 || dataOut !== exp_q[0]) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%0b data=%0h expected valid=1 data=%0h", dataValid, dataOut, exp_q[0]);
      end
      @(negedge rdClk);
    end
    n_checks++;
    if (rdPtrGray !== to_gray(7'd2)) begin n_fail++; $display("FAIL stall_rdptr: got %0h expected %0h", rdPtrGray, to_gray(7'd2)); end
    n_checks++;
    if (numElements !== 7'd3) begin n_fail++; $display("FAIL stall_num: got %0d expected 3", numElements); end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      dataReady = 1'b1;
      if (dataValid) begin
        n_checks++;
        if (dataOut !== exp_q[0]) begin n_fail++; $display("FAIL stall_drain_data: got %0h expected %0h", dataOut, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      @(negedge rdClk);
    end
    dataReady = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_drain_done: got left=%0d empty=%0b expected left=0 empty=1", exp_q.size(), empty);
    end
  endtask

  task automatic test_streaming();
    int waited;
    int gaps;
    int bad;
    apply_reset();
    @(negedge rdClk);
    repeat (DEPTH) write_word();
    dataReady = 1'b1;
    waited = 0;
    while (dataValid !== 1'b1 && waited < 10) begin
      @(negedge rdClk);
      waited++;
    end
    gaps = 0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dataValid !== 1'b1) gaps++;
      else begin
        if (dataOut !== exp_q[0]) begin
          bad++;
          $display("FAIL stream_data_%0d: got %0h expected %0h", i, dataOut, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      @(negedge rdClk);
    end
    n_checks++;
    if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL stream_order: got %0d bad words expected 0", bad); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty: got %0b expected 1", empty); end
    n_checks++;
    if (numElements !== 7'd0) begin n_fail++; $display("FAIL stream_num: got %0d expected 0", numElements); end
    dataReady = 1'b0;
  endtask

  task automatic test_wrap();
    int popped;
    int written;
    int bad;
    logic r;
    apply_reset();
    popped = 0;
    written = 0;
    bad = 0;
    for (int c = 0; c < 4000 && popped < 200; c++) begin
      @(negedge rdClk);
      r = ($urandom_range(0, 2) != 0);
      dataReady = r;
      if (dataValid && r) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wrap_extra_word: got %0h expected no word", dataOut);
        end else begin
          if (dataOut !== exp_q[0]) begin
            bad++;
            $display("FAIL wrap_data_%0d: got %0h expected %0h", popped, dataOut, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        popped++;
      end
      if (written < 200 && exp_q.size() < 60 && $urandom_range(0, 3) != 0) begin
        write_word();
        written++;
      end
    end
    n_checks++;
    if (popped != 200) begin n_fail++; $display("FAIL wrap_count: got %0d expected 200", popped); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL wrap_order: got %0d bad words expected 0", bad); end
    @(negedge rdClk);
    dataReady = 1'b0;
    repeat (6) @(negedge rdClk);
    // 200 words mod 128 leaves the read pointer at 72 after the wrap
    n_checks++;
    if (rdPtrGray !== to_gray(7'd72)) begin n_fail++; $display("FAIL wrap_rdptr: got %0h expected %0h", rdPtrGray, to_gray(7'd72)); end
    n_checks++;
    if (numElements !== 7'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_final: got num=%0d empty=%0b expected num=0 empty=1", numElements, empty);
    end
  endtask

  task automatic test_reset_midstream();
    int waited;
    apply_reset();
    @(negedge rdClk);
    repeat (10) write_word();
    repeat (8) @(negedge rdClk);
    n_checks++;
    if (rdPtrGray !== to_gray(7'd2) || dataValid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_setup: got rdptr=%0h valid=%0b expected rdptr=%0h valid=1", rdPtrGray, dataValid, to_gray(7'd2));
    end
    #2;
    rstn = 1'b0;
    wr_bin = '0;
    wrPtrGray = '0;
    exp_q.delete();
    #1;
    n_checks++;
    if (dataValid !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_valid: got valid=%0b empty=%0b expected valid=0 empty=1", dataValid, empty);
    end
    n_checks++;
    if (rdPtrGray !== '0 || memAddrOut !== '0 || numElements !== '0) begin
      n_fail++;
      $display("FAIL midrst_ptrs: got rdptr=%0h addr=%0h num=%0d expected 0 0 0", rdPtrGray, memAddrOut, numElements);
    end
    repeat (2) @(negedge rdClk);
    rstn = 1'b1;
    dataReady = 1'b1;
    waited = 0;
    repeat (10) begin
      @(negedge rdClk);
      if (dataValid !== 1'b0) waited++;
    end
    n_checks++;
    if (waited != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d valid cycles expected 0", waited); end
    write_word();
    waited = 0;
    while (dataValid !== 1'b1 && waited < 10) begin
      @(negedge rdClk);
      waited++;
    end
    n_checks++;
    if (dataValid !== 1'b1 || dataOut !== exp_q[0]) begin
      n_fail++;
      $display("FAIL midrst_fresh: got valid=%0b data=%0h expected valid=1 data=%0h", dataValid, dataOut, exp_q[0]);
    end
    dataReady = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    dataReady = 1'b0;
    wr_bin = '0;
    wrPtrGray = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_single_word();
    test_stall();
    test_streaming();
    test_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
